// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART link sequencer.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ERR_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_LOAD,
    TX_WAIT,
    DONE
  } link_state_e;

  // Occupancy counter width: holds 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and show-ahead head word.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_link_ctrl.sv
// Half-duplex UART link sequencer: buffer a received burst, then replay it
// through the transmitter in arrival order.
module uart_link_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_err,
  input  logic                      tx_ready,
  input  logic                      tx_done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      receiving,
  output logic                      received,
  output logic                      transmitting,
  output logic                      transmitted,
  output logic [cnt_w(DEPTH)-1:0]   buf_count,
  output logic                      dropped,
  output logic [ERR_W-1:0]          err_count
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BURST   = CNT_W'(BURST_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  link_state_e       state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              receiving_q, receiving_d;
  logic              received_q, received_d;
  logic              transmitting_q, transmitting_d;
  logic              transmitted_q, transmitted_d;
  logic              dropped_q, dropped_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  assign fifo_push = (state_q == RX) & rx_valid & ~rx_err & ~fifo_full;
  assign fifo_pop  = (state_q == TX_LOAD) & ~fifo_empty & tx_ready;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, timeout counter and registered phase flags.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    received_d = 1'b0;
    dropped_d  = dropped_q;
    err_cnt_d  = err_cnt_q;

    if (rx_valid && (state_q != RX)) dropped_d = 1'b1;
    if (rx_valid && !rx_err && fifo_full) dropped_d = 1'b1;
    if (rx_valid && rx_err && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_W'(1);

    case (state_q)
      IDLE: state_d = RX;
      RX: begin
        if (fifo_push) begin
          to_cnt_d = '0;
        end else if ((fifo_count != '0) && (to_cnt_q != TO_LAST)) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
        // A push in the exit cycle still lands in the buffer and is replayed.
        if ((fifo_count >= BURST) || ((fifo_count != '0) && (to_cnt_q == TO_LAST))) begin
          state_d    = TX_LOAD;
          received_d = 1'b1;
        end
      end
      TX_LOAD: begin
        if (fifo_empty) begin
          state_d = DONE;
        end else if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = fifo_dout;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: if (tx_done) state_d = TX_LOAD;
      DONE: begin
        state_d  = RX;
        to_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    receiving_d    = (state_d == RX);
    transmitting_d = (state_d == TX_LOAD) || (state_d == TX_WAIT);
    transmitted_d  = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      to_cnt_q       <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      receiving_q    <= 1'b0;
      received_q     <= 1'b0;
      transmitting_q <= 1'b0;
      transmitted_q  <= 1'b1;
      dropped_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      receiving_q    <= receiving_d;
      received_q     <= received_d;
      transmitting_q <= transmitting_d;
      transmitted_q  <= transmitted_d;
      dropped_q      <= dropped_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign receiving    = receiving_q;
  assign received     = received_q;
  assign transmitting = transmitting_q;
  assign transmitted  = transmitted_q;
  assign buf_count    = fifo_count;
  assign dropped      = dropped_q;
  assign err_count    = err_cnt_q;

endmodule
